// File: rtl/uv_filter_arbiter.sv
// uv_filter_arbiter: round-robin packet scheduler sharing one chroma FIR between U and V streams
// Ports:
//   s00_axis_*  U requester in          s01_axis_*  V requester in
//   m00_axis_*  to shared filter input  s02_axis_*  from shared filter output
//   m01_axis_*  filtered U out          m02_axis_*  filtered V out
//   tags_in_flight  packets granted into the filter whose output tlast has not yet returned
//   s00_axis_aclk / s00_axis_areset  single clock, synchronous active-high reset
module uv_filter_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s01_axis_tdata,
  input  logic                              s01_axis_tvalid,
  input  logic                              s01_axis_tlast,
  output logic                              s01_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s02_axis_tdata,
  input  logic                              s02_axis_tvalid,
  input  logic                              s02_axis_tlast,
  output logic                              s02_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m01_axis_tdata,
  output logic                              m01_axis_tvalid,
  output logic                              m01_axis_tlast,
  input  logic                              m01_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m02_axis_tdata,
  output logic                              m02_axis_tvalid,
  output logic                              m02_axis_tlast,
  input  logic                              m02_axis_tready,
  output logic [$clog2(TAG_DEPTH+1)-1:0]    tags_in_flight
);
  localparam int CW = $clog2(TAG_DEPTH+1);
  localparam int PW = TAG_DEPTH > 1 ? $clog2(TAG_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, FWD_U, FWD_V} state_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic [TAG_DEPTH-1:0] tag_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic push, push_tag, pop, head, busy;
  always_comb begin
    state_d = state_q;
    last_grant_d = last_grant_q;
    push = 1'b0;
    push_tag = 1'b0;
    m00_axis_tdata = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast = 1'b0;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    case (state_q)
      IDLE: if (cnt_q < CW'(TAG_DEPTH) && (s00_axis_tvalid || s01_axis_tvalid)) begin
        // V wins when alone, or on a tie when U was served last
        push_tag = s01_axis_tvalid && (!s00_axis_tvalid || !last_grant_q);
        push = 1'b1;
        last_grant_d = push_tag;
        state_d = push_tag ? FWD_V : FWD_U;
      end
      FWD_U: begin
        m00_axis_tdata = s00_axis_tdata;
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast = s00_axis_tlast;
        s00_axis_tready = m00_axis_tready;
        state_d = s00_axis_tvalid && m00_axis_tready && s00_axis_tlast ? IDLE : FWD_U;
      end
      FWD_V: begin
        m00_axis_tdata = s01_axis_tdata;
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast = s01_axis_tlast;
        s01_axis_tready = m00_axis_tready;
        state_d = s01_axis_tvalid && m00_axis_tready && s01_axis_tlast ? IDLE : FWD_V;
      end
      default: state_d = IDLE;
    endcase
  end
  // Return path: the oldest outstanding tag decides which output owns the filter output
  assign head = tag_q[rd_q];
  assign busy = cnt_q != '0;
  assign s02_axis_tready = busy && (head ? m02_axis_tready : m01_axis_tready);
  assign m01_axis_tvalid = busy && !head && s02_axis_tvalid;
  assign m02_axis_tvalid = busy && head && s02_axis_tvalid;
  assign m01_axis_tdata = s02_axis_tdata;
  assign m02_axis_tdata = s02_axis_tdata;
  assign m01_axis_tlast = s02_axis_tlast;
  assign m02_axis_tlast = s02_axis_tlast;
  assign pop = s02_axis_tvalid && s02_axis_tready && s02_axis_tlast;
  assign tags_in_flight = cnt_q;
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      tag_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      if (push) tag_q[wr_q] <= push_tag;
      if (push) wr_q <= wr_q == PW'(TAG_DEPTH-1) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= rd_q == PW'(TAG_DEPTH-1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_uv_filter_arbiter.sv
// tb_uv_filter_arbiter: table-driven arbitration vectors plus scoreboarded packet scenarios
module tb_uv_filter_arbiter;
  localparam int W = 32;
  localparam int TD = 2;
  typedef struct packed {logic l; logic [W-1:0] d;} beat_t;
  typedef struct packed {logic l; logic [W-1:0] d; int t;} dbeat_t;
  typedef struct {bit u; bit v; bit exp_v;} arb_vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] s00_tdata = '0, s01_tdata = '0;
  logic s00_tvalid = 1'b0, s00_tlast = 1'b0, s01_tvalid = 1'b0, s01_tlast = 1'b0;
  logic s00_tready, s01_tready, s02_tready;
  logic [W-1:0] m00_tdata, m01_tdata, m02_tdata, s02_tdata;
  logic m00_tvalid, m00_tlast, m00_tready, m01_tvalid, m01_tlast, m02_tvalid, m02_tlast;
  logic s02_tvalid, s02_tlast;
  logic m01_tready = 1'b1, m02_tready = 1'b1;
  logic [$clog2(TD+1)-1:0] tags;
  logic drv_en = 1'b0, mode = 1'b0, rdy_en = 1'b1, mon_en = 1'b0, gap_chk = 1'b0;
  logic tu = 1'b0, tv = 1'b0;
  logic [W-1:0] tdu = '0, tdv = '0;
  logic dv = 1'b0, dl = 1'b0;
  logic [W-1:0] dd = '0;
  int cyc = 0, errors = 0, checks = 0;
  int last_end = -1, pkt_n = 0, t_pop1 = -1, t_start3 = -1;
  logic first00 = 1'b1;
  beat_t uq[$], vq[$], exp00[$], exp01[$], exp02[$];
  dbeat_t dq[$];
  arb_vec_t tbl[8];

  uv_filter_arbiter #(.C_AXIS_TDATA_WIDTH(W), .TAG_DEPTH(TD)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tdata(s00_tdata), .s00_axis_tvalid(s00_tvalid), .s00_axis_tlast(s00_tlast), .s00_axis_tready(s00_tready),
    .s01_axis_tdata(s01_tdata), .s01_axis_tvalid(s01_tvalid), .s01_axis_tlast(s01_tlast), .s01_axis_tready(s01_tready),
    .m00_axis_tdata(m00_tdata), .m00_axis_tvalid(m00_tvalid), .m00_axis_tlast(m00_tlast), .m00_axis_tready(m00_tready),
    .s02_axis_tdata(s02_tdata), .s02_axis_tvalid(s02_tvalid), .s02_axis_tlast(s02_tlast), .s02_axis_tready(s02_tready),
    .m01_axis_tdata(m01_tdata), .m01_axis_tvalid(m01_tvalid), .m01_axis_tlast(m01_tlast), .m01_axis_tready(m01_tready),
    .m02_axis_tdata(m02_tdata), .m02_axis_tvalid(m02_tvalid), .m02_axis_tlast(m02_tlast), .m02_axis_tready(m02_tready),
    .tags_in_flight(tags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Filter stub: identity loopback (mode 0, rdy_en gates both sides) or 20-cycle delay line (mode 1)
  assign s02_tvalid = mode ? dv : m00_tvalid && rdy_en;
  assign s02_tdata = mode ? dd : m00_tdata;
  assign s02_tlast = mode ? dl : m00_tlast;
  assign m00_tready = mode ? 1'b1 : s02_tready && rdy_en;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic pkt(input bit v, input int base, input int n);
    for (int i = 1; i <= n; i++) begin
      beat_t b;
      b = {i == n, W'(base + i)};
      exp00.push_back(b);
      if (v) begin vq.push_back(b); exp02.push_back(b); end
      else begin uq.push_back(b); exp01.push_back(b); end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uq.delete(); vq.delete(); exp00.delete(); exp01.delete(); exp02.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp00.size() > 0 || exp01.size() > 0 || exp02.size() > 0 || tags != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, n < 400, 1);
  endtask

  initial forever begin
    logic f;
    @(negedge clk);
    f = s00_tvalid && s00_tready;
    @(posedge clk); #1;
    if (drv_en) begin
      if (f && uq.size() > 0) void'(uq.pop_front());
      s00_tvalid = uq.size() > 0;
      s00_tdata = uq.size() > 0 ? uq[0].d : '0;
      s00_tlast = uq.size() > 0 && uq[0].l;
    end else begin
      s00_tvalid = tu; s00_tdata = tdu; s00_tlast = 1'b1;
    end
  end

  initial forever begin
    logic f;
    @(negedge clk);
    f = s01_tvalid && s01_tready;
    @(posedge clk); #1;
    if (drv_en) begin
      if (f && vq.size() > 0) void'(vq.pop_front());
      s01_tvalid = vq.size() > 0;
      s01_tdata = vq.size() > 0 ? vq[0].d : '0;
      s01_tlast = vq.size() > 0 && vq[0].l;
    end else begin
      s01_tvalid = tv; s01_tdata = tdv; s01_tlast = 1'b1;
    end
  end

  initial forever begin
    logic fin, fout;
    beat_t bin;
    @(negedge clk);
    fin = m00_tvalid && m00_tready;
    bin = {m00_tlast, m00_tdata};
    fout = s02_tvalid && s02_tready;
    @(posedge clk); #1;
    if (rst) dq.delete();
    else begin
      if (mode && fout && dq.size() > 0) void'(dq.pop_front());
      if (mode && fin) dq.push_back({bin.l, bin.d, cyc + 20});
    end
    dv = 1'b0; dd = '0; dl = 1'b0;
    if (dq.size() > 0) begin
      dv = mode && dq[0].t <= cyc;
      dd = dq[0].d;
      dl = dq[0].l;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      first00 = 1'b1; last_end = -1; pkt_n = 0; t_pop1 = -1; t_start3 = -1;
    end else if (mon_en) begin
      chk("tags_bound", tags <= TD, 1);
      chk("src_rdy_excl", s00_tready && s01_tready, 0);
      if (m00_tvalid && m00_tready) begin
        if (first00) begin
          pkt_n++;
          if (pkt_n == 3) t_start3 = cyc;
          if (gap_chk && last_end >= 0) chk("pkt_gap", cyc - last_end, 2);
        end
        chk("m00_have_exp", exp00.size() > 0, 1);
        if (exp00.size() > 0) chk("m00_beat", {m00_tlast, m00_tdata}, exp00.pop_front());
        first00 = m00_tlast;
        if (m00_tlast) last_end = cyc;
      end
      if (m01_tvalid && m01_tready) begin
        chk("m01_have_exp", exp01.size() > 0, 1);
        if (exp01.size() > 0) chk("m01_beat", {m01_tlast, m01_tdata}, exp01.pop_front());
        if (m01_tlast && t_pop1 < 0) t_pop1 = cyc;
      end
      if (m02_tvalid && m02_tready) begin
        chk("m02_have_exp", exp02.size() > 0, 1);
        if (exp02.size() > 0) chk("m02_beat", {m02_tlast, m02_tdata}, exp02.pop_front());
        if (m02_tlast && t_pop1 < 0) t_pop1 = cyc;
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int n, hs;
    tbl[0] = '{1, 1, 0}; tbl[1] = '{1, 1, 1}; tbl[2] = '{1, 0, 0}; tbl[3] = '{1, 0, 0};
    tbl[4] = '{1, 1, 1}; tbl[5] = '{0, 1, 1}; tbl[6] = '{1, 1, 0}; tbl[7] = '{0, 1, 1};
    repeat (3) @(negedge clk);
    chk("rst_m00_tvalid", m00_tvalid, 0);
    chk("rst_m01_tvalid", m01_tvalid, 0);
    chk("rst_m02_tvalid", m02_tvalid, 0);
    chk("rst_readies", {s00_tready, s01_tready, s02_tready}, 0);
    chk("rst_tlasts", {m00_tlast, m01_tlast, m02_tlast}, 0);
    chk("rst_tags", tags, 0);
    rst = 1'b0;
    // Arbitration vectors, starting from reset (last_grant = V)
    for (int i = 0; i < 8; i++) begin
      tu = tbl[i].u; tv = tbl[i].v; tdu = W'(32'h100 + i); tdv = W'(32'h200 + i);
      @(negedge clk);
      chk("arb_idle_no_valid", m00_tvalid, 0);
      @(negedge clk);
      chk("arb_src", m00_tdata, tbl[i].exp_v ? 32'h200 + i : 32'h100 + i);
      chk("arb_win_rdy", tbl[i].exp_v ? s01_tready : s00_tready, 1);
      chk("arb_lose_rdy", tbl[i].exp_v ? s00_tready : s01_tready, 0);
      chk("arb_tags", tags, 1);
      tu = 1'b0; tv = 1'b0;
      @(negedge clk);
    end
    drv_en = 1'b1;
    // Single 8-beat U packet
    do_reset();
    mon_en = 1'b1;
    pkt(0, 0, 8);
    @(negedge clk);
    chk("t1_idle_m00", m00_tvalid, 0);
    chk("t1_idle_tags", tags, 0);
    @(negedge clk);
    chk("t1_first_beat", {m00_tvalid, m00_tdata}, {1'b1, 32'd1});
    chk("t1_tags_one", tags, 1);
    chk("t1_m01_valid", m01_tvalid, 1);
    chk("t1_m02_quiet", m02_tvalid, 0);
    drain("t1");
    chk("t1_tags_zero", tags, 0);
    // Continuous requesters: U,V,U,V with one idle cycle between packets
    do_reset();
    gap_chk = 1'b1;
    pkt(0, 32'h100, 4); pkt(1, 32'h200, 4); pkt(0, 32'h300, 4); pkt(1, 32'h400, 4);
    drain("t2");
    gap_chk = 1'b0;
    // Delayed filter: third grant waits for the first returned tlast
    mode = 1'b1;
    do_reset();
    pkt(0, 32'h100, 4); pkt(1, 32'h200, 4); pkt(0, 32'h300, 4);
    pkt(1, 32'h400, 4); pkt(0, 32'h500, 4); pkt(1, 32'h600, 4);
    drain("t3");
    chk("t3_pop_seen", t_pop1 >= 0, 1);
    chk("t3_third_after_pop", t_start3 >= t_pop1 + 2, 1);
    // Return routing: U at head blocked, V queued behind it
    do_reset();
    m01_tready = 1'b0;
    pkt(0, 32'h500, 4); pkt(1, 32'h600, 4);
    repeat (40) @(negedge clk);
    chk("t4_tags_full", tags, 2);
    chk("t4_s02_valid", s02_tvalid, 1);
    chk("t4_s02_blocked", s02_tready, 0);
    chk("t4_m01_valid", m01_tvalid, 1);
    chk("t4_m02_quiet", m02_tvalid, 0);
    m01_tready = 1'b1;
    drain("t4");
    // m00 ready toggling mid-packet
    mode = 1'b0;
    do_reset();
    pkt(0, 32'h700, 6);
    repeat (2) @(negedge clk);
    pkt(1, 32'h780, 3);
    n = 0;
    while (exp01.size() > 0 && n < 60) begin
      @(posedge clk); #1;
      rdy_en = ~rdy_en;
      @(negedge clk);
      chk("t5_v_locked_out", s01_tready, 0);
      n++;
    end
    rdy_en = 1'b1;
    drain("t5");
    // Reset in the middle of beat 3 of a V packet
    do_reset();
    mon_en = 1'b0;
    pkt(1, 32'h800, 6);
    n = 0; hs = 0;
    while (hs < 2 && n < 50) begin
      @(negedge clk);
      n++;
      if (m00_tvalid && m00_tready) hs++;
    end
    chk("t6_two_beats", hs, 2);
    @(negedge clk);
    chk("t6_beat3", m00_tdata, 32'h803);
    rst = 1'b1;
    uq.delete(); vq.delete(); exp00.delete(); exp01.delete(); exp02.delete();
    @(negedge clk);
    chk("t6_valids", {m00_tvalid, m01_tvalid, m02_tvalid}, 0);
    chk("t6_readies", {s00_tready, s01_tready, s02_tready}, 0);
    chk("t6_m00_tlast", m00_tlast, 0);
    chk("t6_tags", tags, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    pkt(0, 32'h900, 3); pkt(1, 32'hA00, 3);
    repeat (2) @(negedge clk);
    chk("t6_u_first", {m00_tvalid, m00_tdata}, {1'b1, 32'h901});
    drain("t6");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
